// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Program-counter and instruction-fetch stage. Holds the PC, fetches one
// instruction per step from instruction memory over a req/ready handshake and
// presents it, with its PC and decoded opcode / branch offset, to the
// downstream compare/branch logic. The branch unit redirects the PC through
// pc_load_en / pc_load_val.
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   asynchronous, active-low reset
//   stall          in   downstream not accepting; hold the current instruction
//   pc_load_en     in   branch taken; redirect the PC (sampled in VALID only)
//   pc_load_val    in   redirect target, used as-is
//   imem_req       out  fetch request, decoded from state
//   imem_addr      out  fetch address (the PC), stable while imem_req=1
//   imem_ready     in   imem_rdata valid this cycle; completes the request
//   imem_rdata     in   fetched instruction
//   curr_pc        out  PC of the held instruction
//   instr          out  held instruction, 0 when instr_valid=0
//   instr_valid    out  instr and curr_pc are valid
//   opcode         out  instr[15:12]
//   branch_offset  out  instr[3:0]
//   fetch_cnt      out  count of completed fetches, wraps silently
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int                    PC_WIDTH    = 32,
  parameter int                    INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0,
  parameter int                    CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   pc_load_en,
  input  logic [PC_WIDTH-1:0]    pc_load_val,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ready,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [PC_WIDTH-1:0]    curr_pc,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   instr_valid,
  output logic [3:0]             opcode,
  output logic [3:0]             branch_offset,
  output logic [CNT_WIDTH-1:0]   fetch_cnt
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [PC_WIDTH-1:0]    r_pc;
  logic [PC_WIDTH-1:0]    w_pc_nxt;
  logic [PC_WIDTH-1:0]    r_curr_pc;
  logic [PC_WIDTH-1:0]    w_curr_pc_nxt;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic [INSTR_WIDTH-1:0] w_instr_nxt;
  logic                   r_valid;
  logic                   w_valid_nxt;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [CNT_WIDTH-1:0]   w_cnt_nxt;

  // State register; reset forces BOOT so imem_req drops without a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath next values; every register holds unless changed.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_curr_pc_nxt = r_curr_pc;
    w_instr_nxt   = r_instr;
    w_valid_nxt   = r_valid;
    w_cnt_nxt     = r_cnt;
    case (r_state)
      S_BOOT: begin
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        // pc_load_en is deliberately ignored here; the address must stay put
        // until memory completes the request.
        if (imem_ready) begin
          w_instr_nxt   = imem_rdata;
          w_curr_pc_nxt = r_pc;
          w_valid_nxt   = 1'b1;
          w_cnt_nxt     = r_cnt + CNT_WIDTH'(1);
          w_state_nxt   = S_VALID;
        end else begin
          w_state_nxt   = S_FETCH;
        end
      end
      S_VALID: begin
        // A redirect wins over stall: a taken branch never waits.
        if (pc_load_en) begin
          w_pc_nxt    = pc_load_val;
          w_instr_nxt = '0;
          w_valid_nxt = 1'b0;
          w_state_nxt = S_FETCH;
        end else if (!stall) begin
          w_pc_nxt    = r_pc + PC_WIDTH'(1);
          w_instr_nxt = '0;
          w_valid_nxt = 1'b0;
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_VALID;
        end
      end
      default: begin
        // Unreachable encoding: restart cleanly from BOOT with nothing valid.
        w_instr_nxt = '0;
        w_valid_nxt = 1'b0;
        w_state_nxt = S_BOOT;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc      <= RESET_PC;
      r_curr_pc <= '0;
      r_instr   <= '0;
      r_valid   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_pc      <= w_pc_nxt;
      r_curr_pc <= w_curr_pc_nxt;
      r_instr   <= w_instr_nxt;
      r_valid   <= w_valid_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  assign imem_req      = (r_state == S_FETCH);
  assign imem_addr     = r_pc;
  assign curr_pc       = r_curr_pc;
  assign instr         = r_instr;
  assign instr_valid   = r_valid;
  // instr is cleared whenever it is not valid, so these slices read 0 then too.
  assign opcode        = r_instr[15:12];
  assign branch_offset = r_instr[3:0];
  assign fetch_cnt     = r_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. Each completed fetch pushes its expected
// {pc, instr, fetch_cnt} into a scoreboard queue when imem_ready is driven; the
// entry is popped and compared when the DUT presents the instruction. fetch_cnt
// is narrowed to 8 bits so that its wrap is reachable in a short run.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int PW = 32;
  localparam int IW = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          pc_load_en;
  logic [PW-1:0] pc_load_val;
  logic          imem_req;
  logic [PW-1:0] imem_addr;
  logic          imem_ready;
  logic [IW-1:0] imem_rdata;
  logic [PW-1:0] curr_pc;
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic [3:0]    opcode;
  logic [3:0]    branch_offset;
  logic [CW-1:0] fetch_cnt;

  fetch_unit #(
    .PC_WIDTH   (PW),
    .INSTR_WIDTH(IW),
    .RESET_PC   (32'h0000_0000),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .pc_load_en   (pc_load_en),
    .pc_load_val  (pc_load_val),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .curr_pc      (curr_pc),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .opcode       (opcode),
    .branch_offset(branch_offset),
    .fetch_cnt    (fetch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PW-1:0] pc;
    logic [IW-1:0] instr;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sb_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  logic [PW-1:0] m_pc;
  logic [CW-1:0] m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and return at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},    imem_req,      64'd0);
    chk({tag, "_addr"},   imem_addr,     64'd0);
    chk({tag, "_currpc"}, curr_pc,       64'd0);
    chk({tag, "_instr"},  instr,         64'd0);
    chk({tag, "_valid"},  instr_valid,   64'd0);
    chk({tag, "_opcode"}, opcode,        64'd0);
    chk({tag, "_boff"},   branch_offset, 64'd0);
    chk({tag, "_cnt"},    fetch_cnt,     64'd0);
  endtask

  // Called in FETCH: hold ready low for 'waits' cycles, then complete.
  task automatic do_fetch(input logic [IW-1:0] data, input int waits);
    exp_t e;
    for (int i = 0; i < waits; i++) begin
      chk("wait_req",  imem_req,  64'd1);
      chk("wait_addr", imem_addr, 64'(m_pc));
      imem_ready = 1'b0;
      step();
    end
    chk("fetch_req",  imem_req,  64'd1);
    chk("fetch_addr", imem_addr, 64'(m_pc));
    imem_ready = 1'b1;
    imem_rdata = data;
    m_cnt      = m_cnt + 8'd1;
    e.pc       = m_pc;
    e.instr    = data;
    e.cnt      = m_cnt;
    sb_q.push_back(e);
    step();
    imem_ready = 1'b0;
    imem_rdata = 16'($urandom);
    chk("valid_lat", instr_valid, 64'd1);
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL sb_empty observed=0 expected=1");
    end else begin
      e = sb_q.pop_front();
      chk("instr",  instr,         64'(e.instr));
      chk("currpc", curr_pc,       64'(e.pc));
      chk("cnt",    fetch_cnt,     64'(e.cnt));
      chk("opcode", opcode,        64'(e.instr[15:12]));
      chk("boff",   branch_offset, 64'(e.instr[3:0]));
      chk("req_lo", imem_req,      64'd0);
    end
  endtask

  // Called in VALID: accept the instruction and check the refetch.
  task automatic consume();
    stall      = 1'b0;
    pc_load_en = 1'b0;
    step();
    m_pc = m_pc + 32'd1;
    chk("cons_valid",  instr_valid, 64'd0);
    chk("cons_instr",  instr,       64'd0);
    chk("cons_opcode", opcode,      64'd0);
    chk("cons_req",    imem_req,    64'd1);
    chk("cons_addr",   imem_addr,   64'(m_pc));
  endtask

  // Called in VALID: take a branch to 'tgt', optionally with stall raised.
  task automatic redirect(input logic [PW-1:0] tgt, input logic st);
    pc_load_en  = 1'b1;
    pc_load_val = tgt;
    stall       = st;
    step();
    pc_load_en  = 1'b0;
    stall       = 1'b0;
    m_pc        = tgt;
    chk("redir_valid", instr_valid, 64'd0);
    chk("redir_instr", instr,       64'd0);
    chk("redir_req",   imem_req,    64'd1);
    chk("redir_addr",  imem_addr,   64'(tgt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish in time");
  end

  initial begin
    rst         = 1'b1;
    stall       = 1'b0;
    pc_load_en  = 1'b0;
    pc_load_val = 32'h0;
    imem_ready  = 1'b0;
    imem_rdata  = 16'h0;
    m_pc        = 32'h0;
    m_cnt       = 8'h0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");

    // 1: boot, then back-to-back fetches with zero wait
    rst        = 1'b1;
    imem_ready = 1'b1;
    chk("boot_req", imem_req, 64'd0);
    step();
    do_fetch(16'h1000, 0);
    consume();
    do_fetch(16'h2000, 0);
    consume();
    do_fetch(16'h3000, 0);
    consume();
    do_fetch(16'h3100, 0);
    consume();

    // 2: slow memory at 0x4
    do_fetch(16'h4000, 3);
    consume();

    // 3: stall holds the instruction and the PC
    do_fetch(16'h6203, 0);
    for (int i = 0; i < 5; i++) begin
      stall = 1'b1;
      step();
      chk("stall_valid",  instr_valid,   64'd1);
      chk("stall_instr",  instr,         64'h6203);
      chk("stall_currpc", curr_pc,       64'h5);
      chk("stall_opcode", opcode,        64'h6);
      chk("stall_boff",   branch_offset, 64'h3);
      chk("stall_req",    imem_req,      64'd0);
      chk("stall_pc",     imem_addr,     64'h5);
    end
    consume();

    // 4: redirects, including one during stall; pc_load_en ignored in FETCH
    do_fetch(16'h7000, 0);
    redirect(32'h10, 1'b0);
    do_fetch(16'hA5A5, 0);
    redirect(32'h15, 1'b1);
    pc_load_en  = 1'b1;
    pc_load_val = 32'h99;
    step();
    pc_load_en  = 1'b0;
    chk("fetch_ignore_addr", imem_addr, 64'h15);
    do_fetch(16'hB001, 0);

    // 5: PC wrap, then fetch_cnt wrap
    redirect(32'hFFFF_FFFF, 1'b0);
    do_fetch(16'hC00F, 0);
    consume();
    while (m_cnt != 8'hFF) begin
      do_fetch(16'($urandom), 0);
      consume();
    end
    do_fetch(16'($urandom), 0);
    chk("cnt_wrap", fetch_cnt, 64'd0);

    // 6: asynchronous reset during a pending request
    consume();
    #2 rst = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    imem_ready = 1'b1;
    imem_rdata = 16'hDEAD;
    step();
    step();
    chk_reset_vals("late_ready");
    imem_ready = 1'b0;
    rst        = 1'b1;
    m_pc       = 32'h0;
    m_cnt      = 8'h0;
    sb_q.delete();
    chk("reboot_req", imem_req, 64'd0);
    step();
    do_fetch(16'h0F00, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
